// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, condition evaluation and write-strobe gating.
// Define FLAG_SHADOW_EN to add a single-level interrupt shadow of the flags.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       stall,
  input  logic       irq_save,
  input  logic       irq_restore,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       flag_err
);
  logic [3:0] flags_q, flags_d, flags_upd;
  logic       n, z, c, v, upd;
  assign {n, z, c, v} = flags_q;
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = n == v;
      4'b1011: CondEx = n != v;
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
  assign upd       = CondEx & ~stall;
  assign flags_upd = upd ? {FlagW[1] ? ALUFlags[3:2] : flags_q[3:2],
                            FlagW[0] ? ALUFlags[1:0] : flags_q[1:0]} : flags_q;
  assign PCSrc     = PCS & upd;
  assign RegWrite  = RegW & ~NoWrite & upd;
  assign MemWrite  = MemW & upd;
  assign Flags     = flags_q;
`ifdef FLAG_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;
  logic       valid_q, valid_d, err_q, err_d, save, restore;
  // Restore wins over a simultaneous save and over the normal flag update.
  assign restore  = irq_restore & ~stall;
  assign save     = irq_save & ~irq_restore & ~stall;
  assign flags_d  = (restore & valid_q) ? shadow_q : flags_upd;
  assign shadow_d = save ? flags_upd : shadow_q;
  assign valid_d  = restore ? 1'b0 : save ? 1'b1 : valid_q;
  assign err_d    = restore & ~valid_q;
  assign flag_err = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= 4'b0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq_save ^ irq_restore;
  assign flags_d    = flags_upd;
  assign flag_err   = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) flags_q <= FLAG_RST;
    else flags_q <= flags_d;
  end
endmodule
